// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StLuStall = 2'd1,
      StMemWait = 2'd2
   } hz_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // $zero is never a real producer, so a load targeting it cannot create a hazard.
   function automatic logic load_use_hit(input logic       ex_mem_read,
                                         input logic [4:0] ex_rt,
                                         input logic [4:0] id_rs,
                                         input logic [4:0] id_rt,
                                         input logic       id_uses_rt);
      return ex_mem_read && (ex_rt != REG_ZERO) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use stalls,
// data-memory freezes and branch/jump flushes, plus debug counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_is_branch,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             branch_taken,
   input  logic             jump,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             ex_mem_hold,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic             mem_timeout
);

   localparam int unsigned       WaitW   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);
   localparam logic [WaitW-1:0] WaitOne = WaitW'(1);

   hz_state_e        state_q, state_d, eff_state;
   logic [1:0]       stall_left_q, stall_left_d;
   logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;
   logic             lu_hit;
   logic             stall_inc;

   assign lu_hit = load_use_hit(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

   // The cycle that leaves MEM_WAIT behaves exactly like the state it returns to.
   always_comb begin
      eff_state = state_q;
      if ((state_q == StMemWait) && !mem_busy) begin
         eff_state = (stall_left_q != 2'd0) ? StLuStall : StRun;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StRun;
         stall_left_q  <= 2'd0;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         stall_left_q  <= stall_left_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      stall_left_d  = stall_left_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      unique case (eff_state)
         StRun: begin
            if (mem_busy) begin
               state_d    = StMemWait;
               wait_cnt_d = WaitOne;
            end else if (lu_hit && id_is_branch) begin
               state_d      = StLuStall;
               stall_left_d = 2'd1;
            end else begin
               state_d = StRun;
            end
         end
         StLuStall: begin
            // stall_left is kept across a freeze so the second stall cycle still happens.
            if (mem_busy) begin
               state_d    = StMemWait;
               wait_cnt_d = WaitOne;
            end else begin
               state_d      = StRun;
               stall_left_d = 2'd0;
            end
         end
         StMemWait: begin
            if (wait_cnt_q != WaitMax) begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d      = StRun;
            stall_left_d = 2'd0;
         end
      endcase
      if (state_d != StMemWait) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_d == WaitMax) begin
         mem_timeout_d = 1'b1;
      end
   end

   always_comb begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_hold  = 1'b0;
      if (!rst) begin
         unique case (eff_state)
            StRun: begin
               if (mem_busy) begin
                  ex_mem_hold = 1'b1;
               end else if (lu_hit) begin
                  id_ex_bubble = 1'b1;
               end else begin
                  pc_write    = 1'b1;
                  if_id_write = 1'b1;
                  if_id_flush = branch_taken | jump;
               end
            end
            StLuStall: begin
               if (mem_busy) begin
                  ex_mem_hold = 1'b1;
               end else begin
                  id_ex_bubble = 1'b1;
               end
            end
            StMemWait: ex_mem_hold = 1'b1;
            default: ;
         endcase
      end
   end

   assign stall_inc   = !rst && !pc_write;
   assign mem_timeout = mem_timeout_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_count)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (if_id_flush),
      .count (flush_count)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance plus one with a short memory timeout.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
   logic        id_uses_rt = 1'b0, id_is_branch = 1'b0, ex_mem_read = 1'b0;
   logic        branch_taken = 1'b0, jump = 1'b0, mem_busy = 1'b0;

   logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold, mem_timeout;
   logic [15:0] stall_count, flush_count;
   logic        pc_write4, if_id_write4, if_id_flush4, id_ex_bubble4, ex_mem_hold4, mem_timeout4;
   logic [15:0] stall_count4, flush_count4;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk (clk), .rst (rst), .id_rs (id_rs), .id_rt (id_rt), .id_uses_rt (id_uses_rt),
      .id_is_branch (id_is_branch), .ex_mem_read (ex_mem_read), .ex_rt (ex_rt),
      .branch_taken (branch_taken), .jump (jump), .mem_busy (mem_busy),
      .pc_write (pc_write), .if_id_write (if_id_write), .if_id_flush (if_id_flush),
      .id_ex_bubble (id_ex_bubble), .ex_mem_hold (ex_mem_hold), .stall_count (stall_count),
      .flush_count (flush_count), .mem_timeout (mem_timeout)
   );

   hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(4)) dut4 (
      .clk (clk), .rst (rst), .id_rs (id_rs), .id_rt (id_rt), .id_uses_rt (id_uses_rt),
      .id_is_branch (id_is_branch), .ex_mem_read (ex_mem_read), .ex_rt (ex_rt),
      .branch_taken (branch_taken), .jump (jump), .mem_busy (mem_busy),
      .pc_write (pc_write4), .if_id_write (if_id_write4), .if_id_flush (if_id_flush4),
      .id_ex_bubble (id_ex_bubble4), .ex_mem_hold (ex_mem_hold4), .stall_count (stall_count4),
      .flush_count (flush_count4), .mem_timeout (mem_timeout4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 1'b0; id_is_branch = 1'b0;
      ex_mem_read = 1'b0; branch_taken = 1'b0; jump = 1'b0; mem_busy = 1'b0;
   endtask

   initial begin
      #2;
      chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
      chk("rst_if_id_write", {31'd0, if_id_write}, 32'd0);
      chk("rst_counts", {stall_count, flush_count}, 32'd0);
      #448;
      rst = 1'b0;
      step();
      chk("run_pc_write", {31'd0, pc_write}, 32'd1);
      chk("run_bubble", {31'd0, id_ex_bubble}, 32'd0);
      chk("run_stall_count", {16'd0, stall_count}, 32'd0);

      // 1-cycle load-use stall
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      #1;
      chk("lu1_pc_write", {31'd0, pc_write}, 32'd0);
      chk("lu1_if_id_write", {31'd0, if_id_write}, 32'd0);
      chk("lu1_bubble", {31'd0, id_ex_bubble}, 32'd1);
      step();
      idle();
      #1;
      chk("lu1_after_pc_write", {31'd0, pc_write}, 32'd1);
      chk("lu1_after_bubble", {31'd0, id_ex_bubble}, 32'd0);
      chk("lu1_stall_count", {16'd0, stall_count}, 32'd1);

      // load feeding a branch: 2 stall cycles
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_is_branch = 1'b1;
      #1;
      chk("lu2_c1_pc_write", {31'd0, pc_write}, 32'd0);
      chk("lu2_c1_bubble", {31'd0, id_ex_bubble}, 32'd1);
      step();
      idle();
      #1;
      chk("lu2_c2_pc_write", {31'd0, pc_write}, 32'd0);
      chk("lu2_c2_bubble", {31'd0, id_ex_bubble}, 32'd1);
      chk("lu2_c2_stall_count", {16'd0, stall_count}, 32'd2);
      step();
      chk("lu2_c3_pc_write", {31'd0, pc_write}, 32'd1);
      chk("lu2_c3_bubble", {31'd0, id_ex_bubble}, 32'd0);
      chk("lu2_stall_count", {16'd0, stall_count}, 32'd3);

      // taken branch flush
      branch_taken = 1'b1;
      #1;
      chk("br_flush", {31'd0, if_id_flush}, 32'd1);
      chk("br_pc_write", {31'd0, pc_write}, 32'd1);
      step();
      idle();
      #1;
      chk("br_flush_off", {31'd0, if_id_flush}, 32'd0);
      chk("br_flush_count", {16'd0, flush_count}, 32'd1);
      chk("br_stall_count", {16'd0, stall_count}, 32'd3);

      // load-use beats branch; flush follows next cycle
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; branch_taken = 1'b1;
      #1;
      chk("lubr_pc_write", {31'd0, pc_write}, 32'd0);
      chk("lubr_bubble", {31'd0, id_ex_bubble}, 32'd1);
      chk("lubr_no_flush", {31'd0, if_id_flush}, 32'd0);
      step();
      ex_mem_read = 1'b0;
      #1;
      chk("lubr_flush", {31'd0, if_id_flush}, 32'd1);
      chk("lubr_pc_write2", {31'd0, pc_write}, 32'd1);
      step();
      idle();
      #1;
      chk("lubr_flush_count", {16'd0, flush_count}, 32'd2);
      chk("lubr_stall_count", {16'd0, stall_count}, 32'd4);

      // $zero destination and unused rt never stall; used rt does
      ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      #1;
      chk("zero_no_stall", {31'd0, pc_write}, 32'd1);
      ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd3; id_uses_rt = 1'b0;
      #1;
      chk("rt_unused_no_stall", {31'd0, pc_write}, 32'd1);
      id_uses_rt = 1'b1;
      #1;
      chk("rt_used_stall", {31'd0, pc_write}, 32'd0);
      step();
      idle();
      #1;
      chk("rt_stall_count", {16'd0, stall_count}, 32'd5);

      // 5-cycle memory freeze
      mem_busy = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         #1;
         chk("mw_pc_write", {31'd0, pc_write}, 32'd0);
         chk("mw_hold", {31'd0, ex_mem_hold}, 32'd1);
         chk("mw_bubble", {31'd0, id_ex_bubble}, 32'd0);
         step();
         if (k == 3) chk("mw4_timeout_early", {31'd0, mem_timeout4}, 32'd0);
      end
      mem_busy = 1'b0;
      #1;
      chk("mw_exit_pc_write", {31'd0, pc_write}, 32'd1);
      chk("mw_exit_hold", {31'd0, ex_mem_hold}, 32'd0);
      chk("mw_stall_count", {16'd0, stall_count}, 32'd10);
      chk("mw_no_timeout", {31'd0, mem_timeout}, 32'd0);
      chk("mw4_timeout", {31'd0, mem_timeout4}, 32'd1);
      step();
      chk("mw4_timeout_sticky", {31'd0, mem_timeout4}, 32'd1);
      chk("mw_resume_pc_write", {31'd0, pc_write}, 32'd1);

      // reset in the middle of the second load->branch stall cycle
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_is_branch = 1'b1;
      step();
      idle();
      #1;
      chk("rlu_pc_write", {31'd0, pc_write}, 32'd0);
      rst = 1'b1;
      #1;
      chk("rlu_rst_pc_write", {31'd0, pc_write}, 32'd0);
      chk("rlu_rst_bubble", {31'd0, id_ex_bubble}, 32'd0);
      chk("rlu_rst_counts", {stall_count, flush_count}, 32'd0);
      chk("rlu_rst_timeout4", {31'd0, mem_timeout4}, 32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("rlu_rel_pc_write", {31'd0, pc_write}, 32'd1);
      chk("rlu_rel_bubble", {31'd0, id_ex_bubble}, 32'd0);
      step();
      chk("rlu_next_pc_write", {31'd0, pc_write}, 32'd1);
      chk("rlu_stall_count", {16'd0, stall_count}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
